// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, write-no-allocate data cache placed between the CPU
// MEM stage and a word-addressed memory port.
//   CPU side   : cpu_read/cpu_write/cpu_addr/cpu_wdata in; cpu_rdata/cpu_ready out.
//   Memory side: mem_read/mem_write/mem_addr/mem_wdata out; mem_rdata/mem_ready in.
//   Observation: hit (combinational lookup of cpu_addr), access_count, hit_count.
// Read hits complete in the same cycle. Read misses fill the whole line one word at a time and
// then complete on the retried lookup. Every write goes to memory; write hits also update the
// cached word.
module dcache_wt #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned IDX_BITS  = 2,
    parameter int unsigned OFF_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 hit,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [15:0]          access_count,
    output logic [15:0]          hit_count
);

    localparam int unsigned TAG_BITS = WORD_SIZE - IDX_BITS - OFF_BITS;
    localparam int unsigned LINES    = 1 << IDX_BITS;
    localparam int unsigned WORDS    = 1 << OFF_BITS;

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [OFF_BITS-1:0]     fill_cnt_q, fill_cnt_d;
    logic [WORD_SIZE-1:0]    lat_addr_q, lat_addr_d;
    logic [WORD_SIZE-1:0]    lat_wdata_q, lat_wdata_d;
    logic                    filled_q, filled_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [15:0]             access_count_q, access_count_d;
    logic [15:0]             hit_count_q, hit_count_d;

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [WORD_SIZE-1:0]    data_q [LINES*WORDS];

    logic                        data_we;
    logic [IDX_BITS+OFF_BITS-1:0] data_waddr;
    logic [WORD_SIZE-1:0]        data_wval;
    logic                        tag_we;
    logic                        count_hit;

    logic [TAG_BITS-1:0] cpu_tag, lat_tag;
    logic [IDX_BITS-1:0] cpu_idx, lat_idx;
    logic [OFF_BITS-1:0] cpu_off, lat_off;
    logic                lat_hit;

    assign cpu_tag = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign cpu_idx = cpu_addr[OFF_BITS +: IDX_BITS];
    assign cpu_off = cpu_addr[OFF_BITS-1:0];
    assign lat_tag = lat_addr_q[WORD_SIZE-1 -: TAG_BITS];
    assign lat_idx = lat_addr_q[OFF_BITS +: IDX_BITS];
    assign lat_off = lat_addr_q[OFF_BITS-1:0];

    assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign access_count = access_count_q;
    assign hit_count    = hit_count_q;

    always_comb begin
        state_d        = state_q;
        fill_cnt_d     = fill_cnt_q;
        lat_addr_d     = lat_addr_q;
        lat_wdata_d    = lat_wdata_q;
        filled_d       = filled_q;
        valid_d        = valid_q;
        access_count_d = access_count_q;
        hit_count_d    = hit_count_q;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        data_we        = 1'b0;
        data_waddr     = '0;
        data_wval      = '0;
        tag_we         = 1'b0;
        count_hit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Marks only the first IDLE cycle after a fill, where the retried read completes.
                filled_d = 1'b0;
                if (cpu_write) begin
                    lat_addr_d  = cpu_addr;
                    lat_wdata_d = cpu_wdata;
                    state_d     = StWrite;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_q[{cpu_idx, cpu_off}];
                        count_hit = !filled_q;
                    end else begin
                        lat_addr_d       = {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
                        fill_cnt_d       = '0;
                        // Line is overwritten word by word, so it must not hit until complete.
                        valid_d[cpu_idx] = 1'b0;
                        state_d          = StFill;
                    end
                end
            end
            StFill: begin
                mem_read = 1'b1;
                mem_addr = {lat_tag, lat_idx, fill_cnt_q};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_waddr = {lat_idx, fill_cnt_q};
                    data_wval  = mem_rdata;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == OFF_BITS'(WORDS - 1)) begin
                        tag_we           = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        filled_d         = 1'b1;
                        state_d          = StIdle;
                    end
                end
            end
            StWrite: begin
                mem_write = 1'b1;
                mem_addr  = lat_addr_q;
                mem_wdata = lat_wdata_q;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    state_d   = StIdle;
                    if (lat_hit) begin
                        data_we    = 1'b1;
                        data_waddr = {lat_idx, lat_off};
                        data_wval  = lat_wdata_q;
                        count_hit  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (cpu_ready) begin
            access_count_d = access_count_q + 16'd1;
            if (count_hit) hit_count_d = hit_count_q + 16'd1;
        end

        // Keep the interfaces quiet and the arrays untouched while reset is held.
        if (!reset_n) begin
            cpu_ready = 1'b0;
            cpu_rdata = '0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            data_we   = 1'b0;
            tag_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            fill_cnt_q     <= '0;
            lat_addr_q     <= '0;
            lat_wdata_q    <= '0;
            filled_q       <= 1'b0;
            valid_q        <= '0;
            access_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            lat_addr_q     <= lat_addr_d;
            lat_wdata_q    <= lat_wdata_d;
            filled_q       <= filled_d;
            valid_q        <= valid_d;
            access_count_q <= access_count_d;
            hit_count_q    <= hit_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[data_waddr] <= data_wval;
        if (tag_we)  tag_q[lat_idx]     <= lat_tag;
    end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed-vector bench for dcache_wt with a one-wait-state memory model.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, hit;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] access_count, hit_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_model [0:1023];
    int          reads_done  = 0;
    int          writes_done = 0;
    logic [15:0] rd_log [$];
    logic [15:0] last_wr_addr;
    int          both_seen = 0;

    dcache_wt dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .hit          (hit),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .access_count (access_count),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    // Memory: answers each request one cycle after it is seen, with a single-cycle ready pulse.
    always @(posedge clk) begin
        if (mem_read && mem_write) both_seen++;
        if (!reset_n) begin
            mem_ready <= 1'b0;
        end else begin
            if (mem_ready && mem_read) begin
                reads_done++;
                rd_log.push_back(mem_addr);
            end
            if (mem_ready && mem_write) begin
                writes_done++;
                last_wr_addr = mem_addr;
                mem_model[mem_addr[9:0]] = mem_wdata;
            end
            mem_ready <= (mem_read || mem_write) && !mem_ready;
            mem_rdata <= mem_model[mem_addr[9:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access; inputs change at negedge, cpu_ready sampled at negedge.
    task automatic do_acc(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output int cyc, output logic hit0);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        hit0  = hit;
        cyc   = 0;
        rdata = 16'hxxxx;
        while (!cpu_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!cpu_ready) check("timeout", 32'd0, 32'd1);
        else rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] rd;
    int          cyc, r0, w0;
    logic        h0;

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'hA000 + 16'(i);
        mem_model[16'h40] = 16'h1234;
        mem_model[16'h41] = 16'h1111;
        mem_model[16'h42] = 16'h2222;
        mem_model[16'h43] = 16'h3333;
        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0;
        cpu_wdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_mrd",   {31'd0, mem_read}, 32'd0);
        check("rst_mwr",   {31'd0, mem_write}, 32'd0);
        check("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("rst_acc",   {16'd0, access_count}, 32'd0);
        check("rst_hitc",  {16'd0, hit_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Cold miss fills four words.
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0040, 16'h0, rd, cyc, h0);
        check("miss_hitflag", {31'd0, h0}, 32'd0);
        check("miss_nreads", reads_done - r0, 4);
        for (int i = 0; i < 4; i++)
            check("fill_addr", {16'd0, (rd_log.size() > i) ? rd_log[i] : 16'hFFFF}, 32'h40 + i);
        check("miss_rdata", {16'd0, rd}, 32'h1234);
        check("miss_hitc",  {16'd0, hit_count}, 32'd0);
        check("miss_acc",   {16'd0, access_count}, 32'd1);

        // Same-line hit: no stall, no memory traffic.
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0041, 16'h0, rd, cyc, h0);
        check("hit_flag",   {31'd0, h0}, 32'd1);
        check("hit_cycles", cyc, 0);
        check("hit_nreads", reads_done - r0, 0);
        check("hit_rdata",  {16'd0, rd}, 32'h1111);
        check("hit_hitc",   {16'd0, hit_count}, 32'd1);

        // Write hit goes through and updates the line.
        w0 = writes_done;
        do_acc(1'b0, 1'b1, 16'h0042, 16'hBEEF, rd, cyc, h0);
        check("wh_nwrites", writes_done - w0, 1);
        check("wh_addr",    {16'd0, last_wr_addr}, 32'h42);
        check("wh_hitc",    {16'd0, hit_count}, 32'd2);
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0042, 16'h0, rd, cyc, h0);
        check("wh_rd_rdata",  {16'd0, rd}, 32'hBEEF);
        check("wh_rd_nreads", reads_done - r0, 0);
        check("wh_acc",       {16'd0, access_count}, 32'd4);

        // Write miss does not allocate and leaves line 0 intact.
        w0 = writes_done;
        do_acc(1'b0, 1'b1, 16'h0100, 16'h5555, rd, cyc, h0);
        check("wm_nwrites", writes_done - w0, 1);
        check("wm_addr",    {16'd0, last_wr_addr}, 32'h100);
        check("wm_hitc",    {16'd0, hit_count}, 32'd3);
        do_acc(1'b1, 1'b0, 16'h0041, 16'h0, rd, cyc, h0);
        check("wm_line0_hit",   {31'd0, h0}, 32'd1);
        check("wm_line0_rdata", {16'd0, rd}, 32'h1111);
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0100, 16'h0, rd, cyc, h0);
        check("wm_rd_nreads", reads_done - r0, 4);
        check("wm_rd_rdata",  {16'd0, rd}, 32'h5555);
        check("wm_acc",       {16'd0, access_count}, 32'd7);
        check("wm_hitc2",     {16'd0, hit_count}, 32'd4);

        // Conflicting tags in line 0 evict each other.
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0040, 16'h0, rd, cyc, h0);
        check("ev1_nreads", reads_done - r0, 4);
        check("ev1_rdata",  {16'd0, rd}, 32'h1234);
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0050, 16'h0, rd, cyc, h0);
        check("ev2_nreads", reads_done - r0, 4);
        check("ev2_rdata",  {16'd0, rd}, 32'hA050);
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0040, 16'h0, rd, cyc, h0);
        check("ev3_nreads", reads_done - r0, 4);
        check("ev3_rdata",  {16'd0, rd}, 32'h1234);
        check("ev_hitc",    {16'd0, hit_count}, 32'd4);

        // Read and write together: write wins.
        r0 = reads_done;
        w0 = writes_done;
        do_acc(1'b1, 1'b1, 16'h0041, 16'h7777, rd, cyc, h0);
        check("rw_nwrites", writes_done - w0, 1);
        check("rw_nreads",  reads_done - r0, 0);
        do_acc(1'b1, 1'b0, 16'h0041, 16'h0, rd, cyc, h0);
        check("rw_rdata",   {16'd0, rd}, 32'h7777);

        // Reset in the middle of a fill.
        r0 = reads_done;
        cpu_read = 1'b1;
        cpu_addr = 16'h0050;
        for (int i = 0; i < 200 && reads_done < r0 + 2; i++) @(negedge clk);
        check("mid_words", reads_done - r0, 2);
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        cpu_addr = 16'h0040;
        repeat (2) @(negedge clk);
        check("mid_hit",  {31'd0, hit}, 32'd0);
        check("mid_acc",  {16'd0, access_count}, 32'd0);
        check("mid_mrd",  {31'd0, mem_read}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        r0 = reads_done;
        do_acc(1'b1, 1'b0, 16'h0040, 16'h0, rd, cyc, h0);
        check("post_nreads", reads_done - r0, 4);
        check("post_rdata",  {16'd0, rd}, 32'h1234);
        check("post_acc",    {16'd0, access_count}, 32'd1);
        check("post_hitc",   {16'd0, hit_count}, 32'd0);

        check("rd_wr_exclusive", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
